// File: rtl/dff_bist_pkg.sv
// Shared types and constants for the flip-flop BIST controller: FSM state
// encoding, default LFSR seed and the feedback tap mask.
package dff_bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RST_DUT = 3'd1,
        RUN     = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam logic [7:0] DEFAULT_SEED = 8'hA5;
    localparam logic [7:0] TAP_MASK     = 8'hB8;

    // XOR of the tapped bits (7, 5, 4, 3) becomes the new bit 0.
    function automatic logic lfsr_feedback(input logic [7:0] value);
        return ^(value & TAP_MASK);
    endfunction

endpackage

// File: rtl/dff_bist_lfsr.sv
// 8-bit Fibonacci LFSR producing the stimulus pattern, MSB first.
// sout is the current MSB; sout_next is the MSB the register will hold next.
module dff_bist_lfsr
    import dff_bist_pkg::*;
#(
    parameter logic [7:0] SEED = DEFAULT_SEED
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic sout,
    output logic sout_next
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Next-value selection: load wins over shift.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = SEED;
        end else if (enable) begin
            lfsr_d = {lfsr_q[6:0], lfsr_feedback(lfsr_q)};
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // State register; reset parks the LFSR on its seed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign sout      = lfsr_q[7];
    assign sout_next = lfsr_d[7];

endmodule

// File: rtl/dff_bist.sv
// BIST controller for a single D flip-flop: resets it, drives an LFSR pattern
// into d, checks q one cycle later and reports a saturating mismatch count.
module dff_bist
    import dff_bist_pkg::*;
#(
    parameter int         LEN_W = 8,
    parameter logic [7:0] SEED  = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             dut_reset,
    output logic             d_out,
    input  logic             q_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [LEN_W-1:0] err_count
);

    localparam logic [LEN_W-1:0] ALL_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] ALL_ONES = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] ONE      = {{(LEN_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] err_q, err_d;
    logic             exp_q, exp_d;
    logic             exp_vld_q, exp_vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             dut_reset_q, dut_reset_d;
    logic             d_out_q, d_out_d;
    logic             lfsr_load_s, lfsr_en_s, lfsr_out_s, lfsr_next_s;
    logic             mism_s;

    dff_bist_lfsr #(.SEED(SEED)) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .load      (lfsr_load_s),
        .enable    (lfsr_en_s),
        .sout      (lfsr_out_s),
        .sout_next (lfsr_next_s)
    );

    // FSM next state, counters, comparison and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        exp_vld_d   = exp_vld_q;
        pass_d      = pass_q;
        lfsr_load_s = 1'b0;
        lfsr_en_s   = 1'b0;
        mism_s      = 1'b0;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RST_DUT;
                    len_d       = len;
                    cnt_d       = ALL_ZERO;
                    err_d       = ALL_ZERO;
                    pass_d      = 1'b0;
                    exp_vld_d   = 1'b0;
                    lfsr_load_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RST_DUT: begin
                if (cnt_q == ALL_ZERO) begin
                    cnt_d = ONE;
                end else begin
                    mism_s = q_in;
                    if (len_q != ALL_ZERO) begin
                        state_d = RUN;
                        cnt_d   = len_q - ONE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            RUN: begin
                // exp holds the bit driven this cycle; q shows it one cycle later.
                lfsr_en_s = 1'b1;
                exp_d     = lfsr_out_s;
                exp_vld_d = 1'b1;
                mism_s    = exp_vld_q & (q_in ^ exp_q);
                if (cnt_q == ALL_ZERO) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            DRAIN: begin
                mism_s  = exp_vld_q & (q_in ^ exp_q);
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        err_d  = (mism_s && (err_q != ALL_ONES)) ? (err_q + ONE) : err_d;
        pass_d = (state_q == DRAIN) ? (err_d == ALL_ZERO) : pass_d;

        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        dut_reset_d = (state_d != RST_DUT);
        case (state_d)
            RST_DUT: d_out_d = 1'b1;
            RUN:     d_out_d = lfsr_next_s;
            default: d_out_d = 1'b0;
        endcase
    end

    // All state and output registers; reset aborts any test without a done pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            len_q       <= ALL_ZERO;
            cnt_q       <= ALL_ZERO;
            err_q       <= ALL_ZERO;
            exp_q       <= 1'b0;
            exp_vld_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            dut_reset_q <= 1'b0;
            d_out_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            exp_q       <= exp_d;
            exp_vld_q   <= exp_vld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            dut_reset_q <= dut_reset_d;
            d_out_q     <= d_out_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign dut_reset = dut_reset_q;
    assign d_out     = d_out_q;

endmodule

// File: tb/tb_dff_bist.sv
// Self-checking bench for dff_bist: a cycle-indexed model of a test run is
// compared with the DUT every cycle, plus literal checks of the key scenarios.
module tb_dff_bist;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] len;
    logic       dut_reset, d_out, q_in, busy, done, pass;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    dff_bist #(.LEN_W(8), .SEED(8'hA5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .dut_reset (dut_reset),
        .d_out     (d_out),
        .q_in      (q_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Flop under test: 0 good, 1 stuck-at-0, 2 always wrong, 3 random.
    int   q_mode = 0;
    logic ff_q = 1'b0;
    bit   m_expq = 1'b0, m_rnd = 1'b0;

    always @(posedge clk or negedge dut_reset) begin
        if (!dut_reset) ff_q <= 1'b0;
        else            ff_q <= d_out;
    end

    assign q_in = (q_mode == 0) ? ff_q : (q_mode == 1) ? 1'b0 :
                  (q_mode == 2) ? ~m_expq : m_rnd;

    // Model: t counts cycles since start was taken (1,2 reset flop; 3..L+2 run;
    // L+3 drain; L+4 done). pat[i] is the i-th bit sent to d.
    bit m_seen = 1'b0, m_rst = 1'b1, m_act = 1'b0, m_pass = 1'b0;
    int m_t = 0, m_len = 0, m_err = 0;
    bit pat [256];

    initial begin
        bit s_rst, s_start, s_q;
        int s_len;
        logic [7:0] s;
        forever begin
            @(posedge clk);
            s_rst = reset; s_start = start; s_len = int'(len); s_q = q_in;
            #1;
            if (!s_rst) begin
                m_rst = 1'b1; m_act = 1'b0; m_t = 0; m_err = 0; m_pass = 1'b0;
            end else if (!m_act) begin
                m_rst = 1'b0;
                if (s_start) begin
                    m_act = 1'b1; m_t = 1; m_len = s_len; m_err = 0; m_pass = 1'b0;
                    s = 8'hA5;
                    for (int i = 0; i < 256; i++) begin
                        pat[i] = s[7];
                        s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
                    end
                end
            end else begin
                if ((m_t == 2 && s_q != 1'b0) ||
                    (m_t >= 4 && m_t <= m_len + 3 && s_q != pat[m_t - 4])) begin
                    if (m_err < 255) m_err++;
                end
                if (m_t == m_len + 3) m_pass = (m_err == 0);
                if (m_t == m_len + 4) begin
                    m_act = 1'b0; m_t = 0;
                end else begin
                    m_t++;
                end
            end
            m_expq = (m_act && m_t >= 4 && m_t <= m_len + 3) ? pat[m_t - 4] : 1'b0;
            m_rnd  = 1'($urandom_range(1, 0));
            m_seen = 1'b1;
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        int exp_d;
        forever begin
            @(negedge clk);
            if (m_seen) begin
                check("busy", int'(busy), int'(m_act));
                check("done", int'(done), int'(m_act && m_t == m_len + 4));
                check("pass", int'(pass), int'(m_pass));
                check("err_count", int'(err_count), m_err);
                check("dut_reset", int'(dut_reset), (m_rst || (m_act && m_t <= 2)) ? 0 : 1);
                if (!m_act || m_t <= m_len + 2) begin
                    exp_d = (!m_act) ? 0 : (m_t <= 2) ? 1 : int'(pat[m_t - 3]);
                    check("d_out", int'(d_out), exp_d);
                end
            end
        end
    end

    int r_done_k, r_busy, r_first, r_err, r_pass, r_rst_busy, r_rst_err, r_rst_done;

    // One test: start taken at the edge opening cycle k=1; optional start poke
    // and reset pulse land in the given cycle k.
    task automatic run_test(input int L, input int mode, input int poke_k, input int rst_k);
        q_mode = mode;
        @(posedge clk); #1;
        start = 1'b1; len = 8'(L);
        @(posedge clk); #1;
        start = 1'b0; len = 8'($urandom_range(255, 0));
        r_done_k = -1; r_busy = 0; r_first = -1; r_err = -1; r_pass = -1;
        r_rst_busy = -1; r_rst_err = -1; r_rst_done = -1;
        for (int k = 1; k <= L + 12; k++) begin
            @(negedge clk);
            if (k == 3) r_first = int'(d_out);
            if (rst_k > 0 && k == rst_k + 1) begin
                r_rst_busy = int'(busy); r_rst_err = int'(err_count); r_rst_done = int'(done);
            end
            if (done) begin
                r_done_k = k; r_err = int'(err_count); r_pass = int'(pass);
                break;
            end
            if (busy) r_busy++;
            @(posedge clk); #1;
            start = (k + 1 == poke_k);
            reset = !(k + 1 == rst_k);
        end
        start = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        int L, mode, poke;
        reset = 1'b0; start = 1'b0; len = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_err", int'(err_count), 0);
        check("rst_dut_reset", int'(dut_reset), 0);
        check("rst_d_out", int'(d_out), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("idle_dut_reset", int'(dut_reset), 1);

        // Good flop, len=8: busy 11 cycles, then done in cycle 12.
        run_test(8, 0, 0, 0);
        check("good_done_cycle", r_done_k, 12);
        check("good_busy_cycles", r_busy, 11);
        check("good_pass", r_pass, 1);
        check("good_err", r_err, 0);
        check("good_first_run_dout", r_first, 1);

        // Stuck-at-0: pattern from A5 is A5 itself, four ones.
        repeat (2) @(posedge clk);
        run_test(8, 1, 0, 0);
        check("sa0_err", r_err, 4);
        check("sa0_pass", r_pass, 0);
        check("sa0_done_cycle", r_done_k, 12);

        // Zero length: reset x2, drain, done in cycle 4.
        run_test(0, 0, 0, 0);
        check("len0_done_cycle", r_done_k, 4);
        check("len0_pass", r_pass, 1);
        check("len0_err", r_err, 0);

        // Saturation: 256 mismatches clamp to 255.
        run_test(255, 2, 0, 0);
        check("sat_err", r_err, 255);
        check("sat_pass", r_pass, 0);
        check("sat_done_cycle", r_done_k, 259);

        // Reset during RUN cycle 3 (k=5) with a failing flop.
        run_test(8, 2, 0, 5);
        check("abort_busy", r_rst_busy, 0);
        check("abort_err", r_rst_err, 0);
        check("abort_done", r_rst_done, 0);
        check("abort_no_done", r_done_k, -1);

        // Start during RUN is ignored; timing unchanged.
        repeat (2) @(posedge clk);
        run_test(8, 0, 5, 0);
        check("poke_done_cycle", r_done_k, 12);
        check("poke_pass", r_pass, 1);

        for (int n = 0; n < 25; n++) begin
            L    = $urandom_range(40, 0);
            mode = $urandom_range(3, 0);
            poke = ($urandom_range(3, 0) == 0) ? $urandom_range(L + 4, 2) : 0;
            repeat ($urandom_range(3, 0)) @(posedge clk);
            run_test(L, mode, poke, 0);
            check("rand_done_cycle", r_done_k, L + 4);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dff_bist.md
DFF_BIST -- requirements
Module: dff_bist

Interface
REQ-001 The block SHALL have parameter LEN_W, default 8, meaning the width of the pattern-length input and the error counter.
REQ-002 The block SHALL have parameter SEED, default 8'hA5, meaning the LFSR value loaded at each start; a value of 0 is illegal.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle request to begin a test, sampled only in IDLE.
REQ-006 The block SHALL have port len, input, LEN_W bits: the number of pattern bits, latched at start.
REQ-007 The block SHALL have port dut_reset, output, 1 bit: active-low reset to the flop under test.
REQ-008 The block SHALL have port d_out, output, 1 bit: the stimulus to the flop d input.
REQ-009 The block SHALL have port q_in, input, 1 bit: the response from the flop q output.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a test completes.
REQ-012 The block SHALL have port pass, output, 1 bit: the result of the last test, held until the next start.
REQ-013 The block SHALL have port err_count, output, LEN_W bits: the number of mismatches in the last test.

Function
REQ-014 The FSM SHALL have the states IDLE, RST_DUT, RUN, DRAIN and DONE; it SHALL occupy one state per cycle except where stated otherwise.
REQ-015 On start=1 in IDLE, the block SHALL latch len, load the LFSR with SEED, clear err_count and pass, and go to RST_DUT; start SHALL be ignored outside IDLE.
REQ-016 RST_DUT SHALL last exactly 2 cycles with dut_reset=0 and d_out=1.
- On the 2nd RST_DUT cycle, q_in SHALL be checked against 0.
- A nonzero q_in on that cycle SHALL count as one error.
REQ-017 After RST_DUT, the FSM SHALL go to RUN if the latched len is nonzero, or to DRAIN if the latched len is 0.
REQ-018 RUN SHALL last exactly len cycles with dut_reset=1 and d_out=lfsr[7].
- The LFSR SHALL shift left each RUN cycle.
- The new bit 0 SHALL be lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3].
REQ-019 A one-cycle expected-value register SHALL capture d_out every RUN cycle.
- From the 2nd RUN cycle, and in DRAIN, q_in SHALL be compared with this register.
- Each inequality SHALL count as one error.
REQ-020 DRAIN SHALL last 1 cycle and perform the final comparison; no comparison SHALL occur in DRAIN when len=0.
REQ-021 The total time from start to done SHALL be: start cycle + 2 (RST_DUT) + len (RUN) + 1 (DRAIN), followed by 1 cycle in DONE.
REQ-022 In DONE, the block SHALL assert done=1 and set pass=1 exactly when err_count==0, then return to IDLE.
REQ-023 err_count SHALL saturate at all-ones and SHALL never wrap.
REQ-024 In IDLE, dut_reset SHALL be 1 and d_out SHALL be 0.

Reset
REQ-025 When reset=0 at a rising edge, in any state including mid-test, the block SHALL return to IDLE.
REQ-026 While in reset, the outputs SHALL be: busy=0, done=0, pass=0, err_count=0, d_out=0, dut_reset=0, and the LFSR SHALL hold SEED.
REQ-027 After reset is released, the block SHALL drive dut_reset=1 from the first IDLE cycle.
REQ-028 A test aborted by reset SHALL NOT produce a done pulse.

Structure
REQ-029 A shared package dff_bist_pkg SHALL hold the state enum type, the default SEED and the tap mask 8'hB8.
REQ-030 One sub-module, dff_bist_lfsr, SHALL implement the LFSR with load, enable and serial-out ports.
REQ-031 The top level SHALL hold the FSM, the length counter, the expected-value register and the error counter.

Verification
REQ-032 Bench scenario, good flop: with a good dff attached, len=8, start pulse -> busy for 11 cycles, done pulse, pass=1, err_count=0, first RUN d_out=1.
REQ-033 Bench scenario, stuck-at-0: with q_in forced to 0, len=8 -> err_count equals the number of ones in the 8-bit pattern from SEED 8'hA5, and pass=0.
REQ-034 Bench scenario, zero length: len=0 with a good flop -> done 3 cycles after start (RST_DUT x2, DRAIN), pass=1, err_count=0.
REQ-035 Bench scenario, saturation: with q_in=~expected and LEN_W=8, len=255 -> err_count=255 (saturated), no wrap to 0.
REQ-036 Bench scenario, reset mid-test: reset=0 during RUN cycle 3 -> the next cycle shows IDLE, busy=0, no done, err_count=0.
REQ-037 Bench scenario, start while busy: a start pulse during RUN -> ignored, and the current test completes with unchanged timing.
